// File: rtl/add_sub_accum_if.sv
// rtl/add_sub_accum_if.sv - command/result handshake bundle for the add/sub accumulator
interface add_sub_accum_if #(
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [3:0]       b;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       acc;
   logic             c;
   logic             v;
   logic             v_sticky;
   logic [CNT_W-1:0] op_count;

   modport master (
      output in_valid, op, b, out_ready,
      input  in_ready, out_valid, acc, c, v, v_sticky, op_count
   );

   modport slave (
      input  in_valid, op, b, out_ready,
      output in_ready, out_valid, acc, c, v, v_sticky, op_count
   );
endinterface

// File: rtl/add_sub_accum.sv
// rtl/add_sub_accum.sv - 4-bit accumulator stage (LOAD/ADD/SUB/CLEAR) with sticky overflow and op counter
// Optional SATURATE_EN clamps ACC to 0111/1000 on signed overflow instead of wrapping.
module add_sub_accum #(
   parameter int CNT_W = 4
) (
   input logic            clk_i,
   input logic            rst_n_i,
   add_sub_accum_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [3:0]       b_q, b_d;
   logic [3:0]       acc_q, acc_d;
   logic             c_q, c_d;
   logic             v_q, v_d;
   logic             vs_q, vs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             sub_m;
   logic [3:0]       b_eff;
   logic [4:0]       sum;
   logic             ovf;
   logic [3:0]       arith;

   always_comb begin
      sub_m = (op_q == OP_SUB);
      b_eff = b_q ^ {4{sub_m}};
      sum   = {1'b0, acc_q} + {1'b0, b_eff} + {4'd0, sub_m};
      // carry into bit 3 is recovered from the bit-3 sum: c2 = a3 ^ b3 ^ s3
      ovf   = sum[4] ^ (acc_q[3] ^ b_eff[3] ^ sum[3]);
`ifdef SATURATE_EN
      if (ovf) begin
         arith = (!acc_q[3] && !b_eff[3]) ? 4'b0111 : 4'b1000;
      end else begin
         arith = sum[3:0];
      end
`else
      arith = sum[3:0];
`endif
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      b_d     = b_q;
      acc_d   = acc_q;
      c_d     = c_q;
      v_d     = v_q;
      vs_d    = vs_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               op_d    = bus.op;
               b_d     = bus.b;
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = RESP;
            case (op_q)
               OP_LOAD: begin
                  acc_d = b_q;
                  c_d   = 1'b0;
                  v_d   = 1'b0;
               end
               OP_CLEAR: begin
                  acc_d = 4'd0;
                  c_d   = 1'b0;
                  v_d   = 1'b0;
                  vs_d  = 1'b0;
                  cnt_d = '0;
               end
               default: begin
                  acc_d = arith;
                  c_d   = sum[4];
                  v_d   = ovf;
                  vs_d  = vs_q | ovf;
                  if (cnt_q != {CNT_W{1'b1}}) begin
                     cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  end
               end
            endcase
         end
         RESP: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         op_q    <= 2'b00;
         b_q     <= 4'd0;
         acc_q   <= 4'd0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         vs_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
         v_q     <= v_d;
         vs_q    <= vs_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == RESP);
   assign bus.acc       = acc_q;
   assign bus.c         = c_q;
   assign bus.v         = v_q;
   assign bus.v_sticky  = vs_q;
   assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_add_sub_accum.sv
// tb/tb_add_sub_accum.sv - scoreboard bench for add_sub_accum (honours SATURATE_EN when defined)
module tb_add_sub_accum;
   localparam int CNT_W = 4;
   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef struct packed {
      logic [3:0]       acc;
      logic             c;
      logic             v;
      logic             vs;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t model;

   add_sub_accum_if #(.CNT_W(CNT_W)) bus ();
   add_sub_accum #(.CNT_W(CNT_W)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t observe();
      exp_t o;
      o.acc = bus.acc;
      o.c   = bus.c;
      o.v   = bus.v;
      o.vs  = bus.v_sticky;
      o.cnt = bus.op_count;
      return o;
   endfunction

   // reference model in signed/unsigned integer arithmetic
   task automatic model_step(input logic [1:0] op, input logic [3:0] b);
      int  ua, sa, sbv, res;
      bit  add;
      case (op)
         OP_LOAD: begin
            model.acc = b;
            model.c   = 1'b0;
            model.v   = 1'b0;
         end
         OP_CLEAR: model = '0;
         default: begin
            add  = (op == OP_ADD);
            sa   = model.acc[3] ? int'(model.acc) - 16 : int'(model.acc);
            sbv  = b[3] ? int'(b) - 16 : int'(b);
            res  = add ? sa + sbv : sa - sbv;
            ua   = add ? int'(model.acc) + int'(b) : int'(model.acc) - int'(b);
            model.c  = add ? (ua > 15) : (ua >= 0);
            model.v  = (res > 7) || (res < -8);
            model.vs = model.vs | model.v;
            if (model.cnt != 4'hF) model.cnt = model.cnt + 4'd1;
            model.acc = 4'(ua & 15);
`ifdef SATURATE_EN
            if (model.v) model.acc = (res > 7) ? 4'b0111 : 4'b1000;
`endif
         end
      endcase
      sb.push_back(model);
   endtask

   task automatic issue(input logic [1:0] op, input logic [3:0] b, output bit ok);
      model_step(op, b);
      bus.op       = op;
      bus.b        = b;
      bus.in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic await_resp(output exp_t got, output exp_t want, output bit ok, output int lat);
      ok  = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (bus.out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      got  = observe();
      want = (sb.size() > 0) ? sb.pop_front() : '0;
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [3:0] b,
                          output exp_t got, output exp_t want, output bit ok, output int lat);
      bit ok_a, ok_b;
      bus.out_ready = 1'b1;
      issue(op, b, ok_a);
      await_resp(got, want, ok_b, lat);
      ok = ok_a && ok_b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t got;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.op        = 2'b00;
      bus.b         = 4'd0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model = '0;
      sb.delete();
      @(negedge clk);
      got = observe();
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL reset_status: got %h want %h", got, exp_t'('0));
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_add_overflow();
      exp_t got, want;
      bit   ok;
      int   lat;
      logic [3:0] sat_acc;
`ifdef SATURATE_EN
      sat_acc = 4'b0111;
`else
      sat_acc = 4'b1000;
`endif
      run_cmd(OP_LOAD, 4'b0101, got, want, ok, lat);
      checks++;
      if (!ok || got !== want || got.acc !== 4'b0101) begin
         errors++;
         $display("FAIL load_5: ok=%0d got %h want %h", ok, got, want);
      end
      run_cmd(OP_ADD, 4'b0011, got, want, ok, lat);
      checks++;
      if (!ok || got !== want) begin
         errors++;
         $display("FAIL add_ovf: ok=%0d got %h want %h", ok, got, want);
      end
      checks++;
      if (got.acc !== sat_acc || got.c !== 1'b0 || got.v !== 1'b1 || got.vs !== 1'b1 || got.cnt !== 4'd1) begin
         errors++;
         $display("FAIL add_ovf_fields: got %h want acc=%h c=0 v=1 vs=1 cnt=1", got, sat_acc);
      end
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("FAIL latency: got %0d want 2", lat);
      end
   endtask

   task automatic test_sub();
      exp_t got, want;
      bit   ok;
      int   lat;
      run_cmd(OP_LOAD, 4'b0011, got, want, ok, lat);
      run_cmd(OP_SUB, 4'b0101, got, want, ok, lat);
      checks++;
      if (!ok || got !== want) begin
         errors++;
         $display("FAIL sub: ok=%0d got %h want %h", ok, got, want);
      end
      checks++;
      if (got.acc !== 4'b1110 || got.c !== 1'b0 || got.v !== 1'b0 || got.vs !== 1'b1 || got.cnt !== 4'd2) begin
         errors++;
         $display("FAIL sub_fields: got %h want acc=e c=0 v=0 vs=1 cnt=2", got);
      end
   endtask

   task automatic test_carry_clear();
      exp_t got, want;
      bit   ok;
      int   lat;
      run_cmd(OP_LOAD, 4'b1111, got, want, ok, lat);
      run_cmd(OP_ADD, 4'b0001, got, want, ok, lat);
      checks++;
      if (!ok || got !== want || got.acc !== 4'd0 || got.c !== 1'b1 || got.v !== 1'b0) begin
         errors++;
         $display("FAIL carry: ok=%0d got %h want %h", ok, got, want);
      end
      run_cmd(OP_CLEAR, 4'b1010, got, want, ok, lat);
      checks++;
      if (!ok || got !== want || got !== '0) begin
         errors++;
         $display("FAIL clear: ok=%0d got %h want %h", ok, got, want);
      end
   endtask

   task automatic test_backpressure();
      exp_t got, want;
      bit   ok_a, ok_b;
      int   lat;
      bus.out_ready = 1'b0;
      issue(OP_LOAD, 4'b0110, ok_a);
      await_resp(got, want, ok_b, lat);
      checks++;
      if (!ok_a || !ok_b || got !== want) begin
         errors++;
         $display("FAIL bp_load: ok=%0d got %h want %h", ok_a && ok_b, got, want);
      end
      bus.op       = OP_ADD;
      bus.b        = 4'b0001;
      bus.in_valid = 1'b1;
      model_step(OP_ADD, 4'b0001);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.acc !== 4'b0110) begin
            errors++;
            $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b acc=%h want 1 0 6",
                     i, bus.out_valid, bus.in_ready, bus.acc);
         end
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_same: in_ready=%b out_valid=%b want 0 1", bus.in_ready, bus.out_valid);
      end
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release_next: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      await_resp(got, want, ok_b, lat);
      checks++;
      if (!ok_b || got !== want) begin
         errors++;
         $display("FAIL bp_add: ok=%0d got %h want %h", ok_b, got, want);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      exp_t got;
      bit   seen;
      bus.out_ready = 1'b1;
      bus.op        = OP_LOAD;
      bus.b         = 4'b0110;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      model = '0;
      sb.delete();
      @(negedge clk);
      got = observe();
      checks++;
      if (got !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_exec: got %h out_valid=%b in_ready=%b want 0 0 1", got, bus.out_valid, bus.in_ready);
      end

      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen || bus.acc !== 4'b0110) begin
         errors++;
         $display("FAIL rst_resp_pre: seen=%0d acc=%h want 1 6", seen, bus.acc);
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      got = observe();
      checks++;
      if (got !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_resp: got %h out_valid=%b in_ready=%b want 0 0 1", got, bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_count_sat();
      exp_t got, want;
      bit   ok;
      int   lat;
      run_cmd(OP_CLEAR, 4'd0, got, want, ok, lat);
      for (int i = 0; i < 16; i++) begin
         run_cmd(OP_ADD, 4'b0001, got, want, ok, lat);
         checks++;
         if (!ok || got !== want) begin
            errors++;
            $display("FAIL count_add%0d: ok=%0d got %h want %h", i, ok, got, want);
         end
      end
      checks++;
      if (got.cnt !== 4'hF) begin
         errors++;
         $display("FAIL count_sat: got %h want f", got.cnt);
      end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_sub();
      test_carry_clear();
      test_backpressure();
      test_reset_mid();
      test_count_sat();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/add_sub_accum.md
Name: add_sub_accum

Overview:
Sequential accumulator stage wrapped around the 4-bit add/subtract datapath (add_sub). Holds a 4-bit two's-complement accumulator as operand A and applies one command per transaction (LOAD, ADD, SUB, CLEAR) with operand B. Commands arrive on a valid/ready handshake; results leave on a second valid/ready handshake. Adds sticky overflow tracking and an operation counter, so a controller can chain arithmetic without recirculating S0..S3 itself.

Parameters:
CNT_W, 4, width of OP_COUNT; counter saturates at 2^CNT_W-1

Ports:
CLK  input  1  single clock, rising-edge
RST_N  input  1  synchronous active-low reset, sampled on rising CLK
IN_VALID  input  1  command present
IN_READY  output  1  block can accept command
OP  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
B  input  4  operand B, bit 0 = LSB
OUT_VALID  output  1  result available
OUT_READY  input  1  consumer takes result
ACC  output  4  accumulator value, bit 0 = LSB
C  output  1  carry-out of last ADD/SUB (SUB: 1 = no borrow)
V  output  1  signed overflow of last ADD/SUB (c3 XOR c2)
V_STICKY  output  1  OR of V since reset/CLEAR
OP_COUNT  output  CNT_W  number of ADD/SUB completed since reset/CLEAR

Behaviour:
- Reset (RST_N=0 at CLK edge, any state, including mid-transaction): state IDLE; ACC=0, C=0, V=0, V_STICKY=0, OP_COUNT=0, OUT_VALID=0, IN_READY=1; latched OP/B discarded.
- FSM states: IDLE, EXEC, RESP.
- IDLE: IN_READY=1, OUT_VALID=0. On IN_VALID=1: latch OP and B, go to EXEC. IN_VALID=0: stay.
- EXEC (exactly 1 cycle): IN_READY=0. Adder inputs: A=ACC, B=latched B, M=1 for SUB and 0 otherwise. At the closing edge:
  LOAD: ACC<=B; C<=0; V<=0; V_STICKY, OP_COUNT unchanged.
  ADD/SUB: ACC<=S; C<=carry-out; V<=overflow; V_STICKY<=V_STICKY|overflow; OP_COUNT<=OP_COUNT+1, holding at max.
  CLEAR: ACC, C, V, V_STICKY, OP_COUNT <= 0.
  Next state RESP; OUT_VALID<=1.
- RESP: OUT_VALID=1, IN_READY=0. ACC/C/V/V_STICKY/OP_COUNT stable. OUT_READY=1 -> IDLE next edge, OUT_VALID<=0. OUT_READY=0 -> hold indefinitely.
- Latency: command accepted at edge k -> OUT_VALID=1 after edge k+1. Minimum issue interval is 3 cycles with OUT_READY tied high.
- IN_VALID outside IDLE is ignored and causes no state change. The upstream stage keeps the command until IN_READY=1.
- OUT_READY outside RESP has no effect.
- ACC, C, V and the status outputs are registered and change only at the EXEC closing edge or at reset. No combinational path from inputs to outputs except through IN_READY/OUT_VALID, which are state-decoded only.
- Arithmetic is modulo 16; there is no width growth.

Optional Feature:
SATURATE_EN
- Defined: on ADD/SUB with overflow=1, ACC<=0111 if the true result is positive (B3 after M-inversion = 0, A3 = 0), else 1000. C, V and V_STICKY are still reported from the raw adder.
- Undefined: ACC always takes the wrapped adder sum S.

Test Plan:
- Reset then idle: RST_N=0 for 2 cycles, then 1 -> ACC=0000, C=0, V=0, V_STICKY=0, OP_COUNT=0, IN_READY=1, OUT_VALID=0.
- LOAD B=0101, then ADD B=0011 -> after LOAD, ACC=0101. After ADD: ACC=1000, C=0, V=1, V_STICKY=1, OP_COUNT=1. With SATURATE_EN: ACC=0111, V=1.
- LOAD 0011, then SUB B=0101 -> ACC=1110, C=0, V=0, OP_COUNT increments, V_STICKY unchanged.
- LOAD 1111, then ADD 0001 -> ACC=0000, C=1, V=0. CLEAR then -> all status outputs 0.
- Backpressure: OUT_READY=0 for 5 cycles in RESP while IN_VALID=1 -> OUT_VALID stays 1, IN_READY stays 0, ACC is stable, and the new command is accepted only in the cycle after OUT_READY=1.
- Reset mid-EXEC, and separately reset mid-RESP, after LOAD 0110 -> next cycle ACC=0000, state IDLE, OUT_VALID=0. 16 consecutive ADDs -> OP_COUNT saturates at 1111.
